// File: rtl/rt_vc_buffer.sv
// Virtual-channel input buffer for one router port: 4-phase req/ack in, per-VC FIFOs,
// and a round-robin arbitrated 4-phase req/ack output.
module rt_vc_buffer #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 4,
   parameter  int NUM_VC = 2,
   localparam int VC_W   = $clog2(NUM_VC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_req,
   output logic              in_ack,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [VC_W-1:0]   in_vc,
   output logic              out_req,
   input  logic              out_ack,
   output logic [WIDTH-1:0]  out_data,
   output logic [VC_W-1:0]   out_vc,
   output logic [NUM_VC-1:0] vc_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Both ports are 4-phase: req rises with data held stable, ack rises, req falls, ack
   // falls. A new transfer may only start once both lines have returned to 0.
   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem    [NUM_VC][DEPTH];
   logic [PTR_W-1:0] wr_ptr [NUM_VC];
   logic [PTR_W-1:0] rd_ptr [NUM_VC];
   logic [CNT_W-1:0] count     [NUM_VC];
   logic [CNT_W-1:0] count_nxt [NUM_VC];
   logic [VC_W-1:0]  rr;
   logic [VC_W-1:0]  gnt;
   logic [VC_W-1:0]  cand;
   logic             gnt_vld;
   logic             wr_en;
   logic             pop;

   // Full test uses the registered count, so a same-edge pop never opens space early.
   assign wr_en = in_req && !in_ack && (count[in_vc] != CNT_W'(DEPTH));
   assign pop   = (state == IDLE) && gnt_vld;

   // Search starts one past the last winner; VC_W-bit addition wraps the index.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = rr;
      cand    = rr;
      for (int i = 1; i <= NUM_VC; i++) begin
         cand = rr + VC_W'(i);
         if (!gnt_vld && (count[cand] != '0)) begin
            gnt_vld = 1'b1;
            gnt     = cand;
         end
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         count_nxt[v] = count[v];
         if ((wr_en && (in_vc == VC_W'(v))) && !(pop && (gnt == VC_W'(v))))
            count_nxt[v] = count[v] + CNT_W'(1);
         else if (!(wr_en && (in_vc == VC_W'(v))) && (pop && (gnt == VC_W'(v))))
            count_nxt[v] = count[v] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[in_vc][wr_ptr[in_vc]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ack   <= 1'b0;
         out_req  <= 1'b0;
         out_data <= '0;
         out_vc   <= '0;
         vc_full  <= '0;
         rr       <= VC_W'(NUM_VC - 1);
         state    <= IDLE;
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            count[v]  <= '0;
         end
      end else begin
         if (wr_en)
            in_ack <= 1'b1;
         else if (in_ack && !in_req)
            in_ack <= 1'b0;

         for (int v = 0; v < NUM_VC; v++) begin
            count[v]   <= count_nxt[v];
            vc_full[v] <= (count_nxt[v] == CNT_W'(DEPTH));
            if (wr_en && (in_vc == VC_W'(v)))
               wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (pop && (gnt == VC_W'(v)))
               rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
         end

         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  out_data <= mem[gnt][rd_ptr[gnt]];
                  out_vc   <= gnt;
                  rr       <= gnt;
                  out_req  <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (out_ack) begin
                  out_req <= 1'b0;
                  state   <= REL;
               end
            end
            REL: begin
               if (!out_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rt_vc_buffer.sv
// Bench for rt_vc_buffer: directed scenarios plus randomized traffic checked against
// per-VC order queues and an interface-level occupancy model of the FIFOs.
module tb_rt_vc_buffer;

   localparam int W      = 32;
   localparam int DEPTH  = 4;
   localparam int NUM_VC = 2;
   localparam int VC_W   = $clog2(NUM_VC);
   localparam int TW     = W + VC_W;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              in_req  = 1'b0;
   logic              in_ack;
   logic [W-1:0]      in_data = '0;
   logic [VC_W-1:0]   in_vc   = '0;
   logic              out_req;
   logic              out_ack = 1'b0;
   logic [W-1:0]      out_data;
   logic [VC_W-1:0]   out_vc;
   logic [NUM_VC-1:0] vc_full;

   int n_vec = 0;
   int n_err = 0;

   logic [TW-1:0] exp_q[$];
   logic [TW-1:0] got_q[$];

   bit ack_en  = 1'b0;
   int max_dly = 0;
   int dly     = 0;

   int   occ [NUM_VC] = '{default: 0};
   logic in_ack_d  = 1'b0;
   logic out_req_d = 1'b0;

   rt_vc_buffer #(.WIDTH(W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_req   (in_req),
      .in_ack   (in_ack),
      .in_data  (in_data),
      .in_vc    (in_vc),
      .out_req  (out_req),
      .out_ack  (out_ack),
      .out_data (out_data),
      .out_vc   (out_vc),
      .vc_full  (vc_full)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output-side consumer: acks each offered flit after a random delay and records it.
   always @(negedge clk) begin
      if (!rst_n) begin
         out_ack = 1'b0;
         dly     = 0;
      end else if (out_ack) begin
         if (!out_req) out_ack = 1'b0;
      end else if (out_req && ack_en) begin
         if (dly > 0) dly--;
         else begin
            out_ack = 1'b1;
            got_q.push_back({out_vc, out_data});
            dly = $urandom_range(0, max_dly);
         end
      end
   end

   // FIFO occupancy seen from the ports: +1 per accepted flit, -1 per new output offer.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) occ[v] = 0;
         in_ack_d  = 1'b0;
         out_req_d = 1'b0;
      end else begin
         if (in_ack && !in_ack_d) occ[in_vc]++;
         if (out_req && !out_req_d) occ[out_vc]--;
         for (int v = 0; v < NUM_VC; v++)
            check($sformatf("vc_full[%0d]", v), vc_full[v], (occ[v] == DEPTH));
         in_ack_d  = in_ack;
         out_req_d = out_req;
      end
   end

   task automatic send_flit(input logic [VC_W-1:0] vc, input logic [W-1:0] d,
                            input int budget, output bit ok);
      in_vc   = vc;
      in_data = d;
      in_req  = 1'b1;
      ok      = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (in_ack) ok = 1'b1;
      end
      if (ok) exp_q.push_back({vc, d});
      in_req = 1'b0;
      @(negedge clk);
      if (ok) check("in_ack_release", in_ack, 1'b0);
   endtask

   // Match every captured flit to the oldest expected flit of the same VC.
   task automatic drain(input int budget);
      logic [TW-1:0] g;
      int  idx;
      bit  done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         while (got_q.size() > 0) begin
            g   = got_q.pop_front();
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
               if (idx < 0 && exp_q[i][TW-1:W] == g[TW-1:W]) idx = i;
            check("flit_vc_expected", (idx >= 0), 1'b1);
            if (idx >= 0) begin
               check("flit_data", g[W-1:0], exp_q[idx][W-1:0]);
               exp_q.delete(idx);
            end
         end
         if (exp_q.size() == 0) done = 1'b1;
      end
      check("drain_complete", done, 1'b1);
      repeat (6) @(negedge clk);
      check("no_extra_flits", got_q.size(), 0);
      check("out_req_idle", out_req, 1'b0);
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      bit ok;
      bit seen;
      logic [W-1:0] order [4];

      // Reset state
      #2;
      check("rst_in_ack", in_ack, 1'b0);
      check("rst_out_req", out_req, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_vc", out_vc, '0);
      check("rst_vc_full", vc_full, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single flit latency
      ack_en  = 1'b1;
      max_dly = 0;
      in_vc   = '0;
      in_data = 32'hDEADBEEF;
      in_req  = 1'b1;
      @(negedge clk);
      check("t1_in_ack", in_ack, 1'b1);
      check("t1_out_req_early", out_req, 1'b0);
      in_req = 1'b0;
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      @(negedge clk);
      check("t1_out_req", out_req, 1'b1);
      check("t1_out_data", out_data, 32'hDEADBEEF);
      check("t1_out_vc", out_vc, 1'b0);
      drain(20);

      // Fill VC1 with the consumer stalled; a sixth flit waits for space
      ack_en  = 1'b0;
      max_dly = 0;
      for (int k = 0; k < 5; k++) begin
         send_flit(1'b1, $urandom, 20, ok);
         check("t2_acked", ok, 1'b1);
      end
      check("t2_vc_full", vc_full, 2'b10);
      in_vc   = 1'b1;
      in_data = 32'h0000_0606;
      in_req  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t2_no_ack_full", in_ack, 1'b0);
      end
      ack_en = 1'b1;
      seen   = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (got_q.size() > 0) seen = 1'b1;
      end
      ack_en = 1'b0;
      check("t2_pulse_taken", seen, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         if (in_ack) seen = 1'b1;
      end
      check("t2_sixth_acked", seen, 1'b1);
      if (seen) exp_q.push_back({1'b1, 32'h0000_0606});
      in_req = 1'b0;
      @(negedge clk);
      check("t2_refull", vc_full, 2'b10);
      ack_en  = 1'b1;
      max_dly = 3;
      drain(200);

      // Round-robin interleave across VCs
      ack_en = 1'b0;
      send_flit(1'b0, 32'hA0, 20, ok); check("t3_a0", ok, 1'b1);
      send_flit(1'b0, 32'hA1, 20, ok); check("t3_a1", ok, 1'b1);
      send_flit(1'b1, 32'hB0, 20, ok); check("t3_b0", ok, 1'b1);
      send_flit(1'b1, 32'hB1, 20, ok); check("t3_b1", ok, 1'b1);
      order[0] = 32'hA0; order[1] = 32'hB0; order[2] = 32'hA1; order[3] = 32'hB1;
      ack_en  = 1'b1;
      max_dly = 1;
      seen    = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (got_q.size() >= 4) seen = 1'b1;
      end
      check("t3_four_out", seen, 1'b1);
      if (seen)
         for (int k = 0; k < 4; k++)
            check($sformatf("t3_order%0d", k), got_q[k][W-1:0], order[k]);
      drain(40);

      // Stream 1..10 into VC0 with random output ack delays
      ack_en  = 1'b1;
      max_dly = 5;
      for (int k = 1; k <= 10; k++) begin
         send_flit(1'b0, W'(k), 200, ok);
         check("t4_acked", ok, 1'b1);
      end
      drain(400);

      // Asynchronous reset with a full VC, an offered flit and a held input ack
      ack_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_flit(1'b0, $urandom, 20, ok);
         check("t5_acked", ok, 1'b1);
      end
      in_vc   = 1'b1;
      in_data = $urandom;
      in_req  = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (in_ack) seen = 1'b1;
      end
      check("t5_pre_in_ack", in_ack, 1'b1);
      check("t5_pre_out_req", out_req, 1'b1);
      check("t5_pre_vc_full", vc_full, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_out_req", out_req, 1'b0);
      check("t5_rst_in_ack", in_ack, 1'b0);
      check("t5_rst_vc_full", vc_full, '0);
      in_req = 1'b0;
      exp_q.delete();
      got_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("t5_no_out_req", out_req, 1'b0);
      end
      ack_en  = 1'b1;
      max_dly = 2;
      send_flit(1'b1, 32'h5555_AAAA, 20, ok);
      check("t5_new_acked", ok, 1'b1);
      drain(40);

      // in_req held high long after the ack: exactly one write
      in_vc   = 1'b0;
      in_data = $urandom;
      in_req  = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (in_ack) seen = 1'b1;
      end
      check("t6_acked", seen, 1'b1);
      if (seen) exp_q.push_back({in_vc, in_data});
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t6_ack_held", in_ack, 1'b1);
      end
      in_req = 1'b0;
      @(negedge clk);
      check("t6_ack_drop", in_ack, 1'b0);
      drain(40);

      // Randomized mixed-VC traffic
      ack_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         max_dly = $urandom_range(0, 5);
         send_flit(VC_W'($urandom_range(0, NUM_VC - 1)), $urandom, 300, ok);
         check("t7_acked", ok, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      max_dly = 3;
      drain(1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
